// File: rtl/hsi_obi_cmd_master.sv
// OBI initiator that runs one HSI vector-core job: program op code and band count,
// start the core, poll STATUS until done/error/timeout, then clear the sticky flags.
module hsi_obi_cmd_master #(
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int          OP_CODE_WIDTH   = 4,
  parameter int          NUM_BANDS_WIDTH = 32,
  parameter int          ERR_WIDTH       = 4,
  parameter int          POLL_GAP        = 4,
  parameter int          TIMEOUT_POLLS   = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [OP_CODE_WIDTH-1:0]   cmd_op_code_i,
  input  logic [NUM_BANDS_WIDTH-1:0] cmd_num_bands_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic                       rsp_done_o,
  output logic [ERR_WIDTH-1:0]       rsp_err_code_o,
  output logic                       rsp_bus_err_o,
  output logic                       rsp_timeout_o,
  output logic                       req_o,
  output logic                       we_o,
  output logic [3:0]                 be_o,
  output logic [31:0]                addr_o,
  output logic [31:0]                wdata_o,
  input  logic                       gnt_i,
  input  logic                       rvalid_i,
  input  logic [31:0]                rdata_i,
  input  logic                       err_i
);

  localparam int PollW = $clog2(TIMEOUT_POLLS + 1);
  localparam int GapW  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {
    IDLE, WR_OP, WR_NB, WR_START, RD_STATUS, GAP, WR_CLEAR, RESP
  } state_e;

  typedef enum logic {PH_REQ, PH_WAIT} phase_e;

  state_e                     state_q, state_d;
  phase_e                     phase_q, phase_d;
  logic [PollW-1:0]           poll_cnt_q, poll_cnt_d, poll_inc;
  logic [GapW-1:0]            gap_cnt_q, gap_cnt_d;
  logic [OP_CODE_WIDTH-1:0]   op_q, op_d;
  logic [NUM_BANDS_WIDTH-1:0] nb_q, nb_d;
  logic                       done_q, done_d;
  logic [ERR_WIDTH-1:0]       err_code_q, err_code_d;
  logic                       bus_err_q, bus_err_d;
  logic                       timeout_q, timeout_d;

  logic                       access;
  logic                       acc_we;
  logic [7:0]                 acc_off;
  logic [31:0]                acc_wdata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      phase_q    <= PH_REQ;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      op_q       <= '0;
      nb_q       <= '0;
      done_q     <= 1'b0;
      err_code_q <= '0;
      bus_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      op_q       <= op_d;
      nb_q       <= nb_d;
      done_q     <= done_d;
      err_code_q <= err_code_d;
      bus_err_q  <= bus_err_d;
      timeout_q  <= timeout_d;
    end
  end

  // Register-window decode for the access the current state performs.
  always_comb begin
    access    = 1'b1;
    acc_we    = 1'b1;
    acc_off   = 8'h00;
    acc_wdata = 32'h0;
    case (state_q)
      WR_OP:     acc_wdata = 32'(op_q);
      WR_NB:     begin acc_off = 8'h04; acc_wdata = 32'(nb_q); end
      WR_START:  begin acc_off = 8'h08; acc_wdata = 32'h1; end
      RD_STATUS: begin acc_off = 8'h0C; acc_we = 1'b0; end
      WR_CLEAR:  begin acc_off = 8'h08; acc_wdata = 32'h6; end
      default:   begin access = 1'b0; acc_we = 1'b0; end
    endcase
  end

  assign req_o       = access && (phase_q == PH_REQ);
  assign we_o        = acc_we;
  assign be_o        = access ? 4'hF : 4'h0;
  assign addr_o      = access ? (BASE_ADDR + {24'h0, acc_off}) : 32'h0;
  assign wdata_o     = acc_wdata;
  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);

  assign rsp_done_o     = done_q;
  assign rsp_err_code_o = err_code_q;
  assign rsp_bus_err_o  = bus_err_q;
  assign rsp_timeout_o  = timeout_q;

  assign poll_inc = poll_cnt_q + PollW'(1);

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    op_d       = op_q;
    nb_d       = nb_q;
    done_d     = done_q;
    err_code_d = err_code_q;
    bus_err_d  = bus_err_q;
    timeout_d  = timeout_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          op_d       = cmd_op_code_i;
          nb_d       = cmd_num_bands_i;
          done_d     = 1'b0;
          err_code_d = '0;
          bus_err_d  = 1'b0;
          timeout_d  = 1'b0;
          poll_cnt_d = '0;
          phase_d    = PH_REQ;
          state_d    = WR_OP;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = RD_STATUS;
        else                 gap_cnt_d = gap_cnt_q - GapW'(1);
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: begin
        if (phase_q == PH_REQ) begin
          if (gnt_i) phase_d = PH_WAIT;
        end else if (rvalid_i) begin
          phase_d = PH_REQ;
          if (err_i) begin
            bus_err_d = 1'b1;
            state_d   = RESP;
          end else begin
            case (state_q)
              WR_OP:    state_d = WR_NB;
              WR_NB:    state_d = WR_START;
              WR_START: state_d = RD_STATUS;
              WR_CLEAR: state_d = RESP;
              RD_STATUS: begin
                poll_cnt_d = poll_inc;
                // Error wins the report, but a simultaneous done bit is kept too.
                if (rdata_i[ERR_WIDTH:1] != '0) begin
                  err_code_d = rdata_i[ERR_WIDTH:1];
                  done_d     = rdata_i[0];
                  state_d    = WR_CLEAR;
                end else if (rdata_i[0]) begin
                  done_d  = 1'b1;
                  state_d = WR_CLEAR;
                end else if (poll_inc == PollW'(TIMEOUT_POLLS)) begin
                  timeout_d = 1'b1;
                  state_d   = RESP;
                end else if (POLL_GAP == 0) begin
                  state_d = RD_STATUS;
                end else begin
                  gap_cnt_d = GapW'(POLL_GAP - 1);
                  state_d   = GAP;
                end
              end
              default: state_d = state_q;
            endcase
          end
        end
      end
    endcase
  end

endmodule
